// File: rtl/imm_ext_pipe.sv
// Immediate-generation stage between ID and EX: decodes the immediate at acceptance
// and holds it in an output register backed by one skid entry under back-pressure.
module imm_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [25:0]       instr,
  input  logic [DATA_W-1:0] pc4,
  input  logic [2:0]        ext_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm,
  output logic [TAG_W-1:0]  out_tag,
  output logic              illegal
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // the output transfers on a rising edge where out_valid && out_ready.

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  logic              out_v, skid_v;
  logic [DATA_W-1:0] out_imm, skid_imm;
  logic [TAG_W-1:0]  out_tag_r, skid_tag;
  logic              out_ill, skid_ill;
  state_t            state;

  logic [15:0]       i16;
  logic [DATA_W-1:0] sext16;
  logic [DATA_W-1:0] new_imm;
  logic              new_ill;
  logic              accept;
  logic              unused_pc_bits;

  assign i16            = instr[15:0];
  assign sext16         = {{(DATA_W-16){i16[15]}}, i16};
  assign unused_pc_bits = ^pc4[27:0];

  always_comb begin
    new_imm = '0;
    new_ill = 1'b0;
    case (ext_op)
      3'd0: new_imm = {{(DATA_W-16){1'b0}}, i16};
      3'd1: new_imm = sext16;
      // Shifting the sign-extended value keeps the upper bits as sign copies at 64 bits.
      3'd2: new_imm = sext16 << 16;
      3'd3: new_imm = sext16 << 2;
      3'd4: new_imm = {pc4[DATA_W-1:28], instr, 2'b00};
      3'd5: new_imm = {{(DATA_W-5){1'b0}}, instr[10:6]};
      default: begin
        new_imm = '0;
        new_ill = 1'b1;
      end
    endcase
  end

  assign state     = skid_v ? FULL : (out_v ? ONE : EMPTY);
  assign in_ready  = ~skid_v;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_v;
  assign imm       = out_imm;
  assign out_tag   = out_tag_r;
  assign illegal   = out_ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v     <= 1'b0;
      skid_v    <= 1'b0;
      out_imm   <= '0;
      out_tag_r <= '0;
      out_ill   <= 1'b0;
      skid_imm  <= '0;
      skid_tag  <= '0;
      skid_ill  <= 1'b0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_v     <= 1'b1;
            out_imm   <= new_imm;
            out_tag_r <= in_tag;
            out_ill   <= new_ill;
          end
        end
        ONE: begin
          if (accept && !out_ready) begin
            skid_v   <= 1'b1;
            skid_imm <= new_imm;
            skid_tag <= in_tag;
            skid_ill <= new_ill;
          end else if (accept) begin
            out_imm   <= new_imm;
            out_tag_r <= in_tag;
            out_ill   <= new_ill;
          end else if (out_ready) begin
            out_v <= 1'b0;
          end
        end
        FULL: begin
          // in_ready is low here, so nothing new can arrive; only the skid drains.
          if (out_ready) begin
            skid_v    <= 1'b0;
            out_imm   <= skid_imm;
            out_tag_r <= skid_tag;
            out_ill   <= skid_ill;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
